// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - USB packet transmitter: SYNC, PID, DATA, CRC16 and EOP fields, NRZI line coding, bit stuffing.
// Defining USB_TX_DIV4_EN stretches each bit time to 4 clocks.
module usb_tx (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       TX_Start,
  input  logic [1:0] TX_Packet,
  input  logic [6:0] Buffer_Occupancy,
  input  logic [7:0] TX_Packet_Data,
  output logic       Dplus_Out,
  output logic       Dminus_Out,
  output logic       TX_Transfer_Active,
  output logic       TX_Error,
  output logic       Get_TX_Packet_Data
);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  pkt_q, pkt_d;
  logic [6:0]  left_q, left_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] crc_q, crc_d;
  logic [2:0]  ones_q, ones_d;
  logic        stuff_q, stuff_d;
  logic        lvl_q, lvl_d;
  logic        err_q, err_d;

  logic        tick;
  logic        bit_now;
  logic        lvl_now;
  logic        get;
  logic        need_byte;
  logic [3:0]  pid;
  logic [7:0]  pid_byte;

`ifdef USB_TX_DIV4_EN
  logic [1:0] div_q, div_d;

  always_comb begin
    div_d = (state_q == IDLE) ? 2'd0 : div_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) div_q <= 2'd0;
    else        div_q <= div_d;
  end

  assign tick = (div_q == 2'd3);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    case (pkt_q)
      2'd0:    pid = 4'b0011;
      2'd1:    pid = 4'b0010;
      2'd2:    pid = 4'b1010;
      default: pid = 4'b1110;
    endcase
  end

  assign pid_byte = {~pid, pid};

  // Bit currently on the line; a pending stuff bit overrides the field contents.
  always_comb begin
    bit_now = 1'b1;
    if (stuff_q) begin
      bit_now = 1'b0;
    end else begin
      case (state_q)
        SYNC:    bit_now = (cnt_q == 4'd7);
        PID:     bit_now = pid_byte[cnt_q[2:0]];
        DATA:    bit_now = data_q[cnt_q[2:0]];
        CRC:     bit_now = ~crc_q[cnt_q];
        default: bit_now = 1'b1;
      endcase
    end
  end

  assign lvl_now = bit_now ? lvl_q : ~lvl_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pkt_d     = pkt_q;
    left_d    = left_q;
    data_d    = data_q;
    crc_d     = crc_q;
    ones_d    = ones_q;
    stuff_d   = stuff_q;
    lvl_d     = lvl_q;
    err_d     = 1'b0;
    get       = 1'b0;
    need_byte = 1'b0;
    case (state_q)
      IDLE: begin
        lvl_d   = 1'b1;
        ones_d  = 3'd0;
        stuff_d = 1'b0;
        cnt_d   = 4'd0;
        crc_d   = 16'hFFFF;
        if (TX_Start) begin
          pkt_d  = TX_Packet;
          left_d = Buffer_Occupancy;
          if (Buffer_Occupancy > 7'd64) err_d   = 1'b1;
          else                          state_d = SYNC;
        end
      end
      default: begin
        if (tick) begin
          if (stuff_q) begin
            stuff_d = 1'b0;
            lvl_d   = lvl_now;
          end else if (state_q == EOP) begin
            if (cnt_q == 4'd2) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            lvl_d = lvl_now;
            if (bit_now) begin
              if (ones_q == 3'd5) begin
                ones_d  = 3'd0;
                stuff_d = 1'b1;
              end else begin
                ones_d = ones_q + 3'd1;
              end
            end else begin
              ones_d = 3'd0;
            end
            cnt_d = cnt_q + 4'd1;
            case (state_q)
              SYNC: begin
                if (cnt_q == 4'd7) begin
                  state_d = PID;
                  cnt_d   = 4'd0;
                end
              end
              PID: begin
                if (cnt_q == 4'd7) begin
                  cnt_d = 4'd0;
                  if (pkt_q != 2'd0)       state_d   = EOP;
                  else if (left_q == 7'd0) state_d   = CRC;
                  else                     need_byte = 1'b1;
                end
              end
              DATA: begin
                crc_d = {1'b0, crc_q[15:1]} ^ ((bit_now ^ crc_q[0]) ? 16'hA001 : 16'h0000);
                if (cnt_q == 4'd7) begin
                  cnt_d = 4'd0;
                  if (left_q == 7'd0) state_d   = CRC;
                  else                need_byte = 1'b1;
                end
              end
              CRC: begin
                if (cnt_q == 4'd15) begin
                  state_d = EOP;
                  cnt_d   = 4'd0;
                end
              end
              default: ;
            endcase
            // Next byte is fetched on the last bit of the current field so bytes run back to back.
            if (need_byte) begin
              if (Buffer_Occupancy == 7'd0) begin
                err_d   = 1'b1;
                state_d = EOP;
              end else begin
                get     = 1'b1;
                data_d  = TX_Packet_Data;
                left_d  = left_q - 7'd1;
                state_d = DATA;
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pkt_q   <= 2'd0;
      left_q  <= 7'd0;
      data_q  <= 8'd0;
      crc_q   <= 16'hFFFF;
      ones_q  <= 3'd0;
      stuff_q <= 1'b0;
      lvl_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      left_q  <= left_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      ones_q  <= ones_d;
      stuff_q <= stuff_d;
      lvl_q   <= lvl_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    Dplus_Out  = 1'b1;
    Dminus_Out = 1'b0;
    if (state_q != IDLE) begin
      if (stuff_q || (state_q != EOP)) begin
        Dplus_Out  = lvl_now;
        Dminus_Out = ~lvl_now;
      end else if (cnt_q != 4'd2) begin
        Dplus_Out  = 1'b0;
        Dminus_Out = 1'b0;
      end
    end
  end

  assign TX_Transfer_Active = (state_q != IDLE);
  assign TX_Error           = err_q;
  assign Get_TX_Packet_Data = get;

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - randomized self-checking bench for usb_tx against a bit-stream reference model.
module tb_usb_tx;

`ifdef USB_TX_DIV4_EN
  localparam int BT = 4;
`else
  localparam int BT = 1;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       TX_Start = 1'b0;
  logic [1:0] TX_Packet = 2'd0;
  logic [6:0] buf_occ = 7'd0;
  logic [7:0] buf_data = 8'd0;
  logic       force_occ = 1'b0;
  logic [6:0] forced_occ = 7'd0;
  logic [6:0] occ_in;
  logic       Dplus_Out, Dminus_Out, TX_Transfer_Active, TX_Error, Get_TX_Packet_Data;

  logic [7:0] bq[$];
  logic [7:0] model_bytes[$];
  logic [1:0] exp_q[$];
  logic       drain_after_one = 1'b0;
  logic       pop_pend = 1'b0;
  int         get_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  assign occ_in = force_occ ? forced_occ : buf_occ;

  usb_tx dut (
    .clk(clk),
    .n_rst(n_rst),
    .TX_Start(TX_Start),
    .TX_Packet(TX_Packet),
    .Buffer_Occupancy(occ_in),
    .TX_Packet_Data(buf_data),
    .Dplus_Out(Dplus_Out),
    .Dminus_Out(Dminus_Out),
    .TX_Transfer_Active(TX_Transfer_Active),
    .TX_Error(TX_Error),
    .Get_TX_Packet_Data(Get_TX_Packet_Data)
  );

  always #5 clk = ~clk;

  task automatic refresh_buf();
    buf_occ  = 7'(bq.size());
    buf_data = (bq.size() > 0) ? bq[0] : 8'h00;
  endtask

  // FWFT buffer: a pop strobed in one clock takes effect after the edge that ends it.
  always @(negedge clk) begin
    if (pop_pend) begin
      if (bq.size() > 0) void'(bq.pop_front());
      if (drain_after_one) bq.delete();
      refresh_buf();
    end
    pop_pend = Get_TX_Packet_Data;
    if (Get_TX_Packet_Data === 1'b1) get_cnt++;
  end

  // Line symbols per clock: {D+, D-}; J=10, K=01, SE0=00.
  task automatic build_exp(input logic [1:0] pkt, input int nbytes, input bit with_crc);
    bit         raw[$];
    bit         st[$];
    logic [3:0] pid;
    logic [15:0] r;
    logic [7:0] b;
    logic       fb;
    logic       lvl;
    int         ones;
    exp_q.delete();
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    case (pkt)
      2'd0: pid = 4'b0011;
      2'd1: pid = 4'b0010;
      2'd2: pid = 4'b1010;
      default: pid = 4'b1110;
    endcase
    for (int i = 0; i < 4; i++) raw.push_back(pid[i]);
    for (int i = 0; i < 4; i++) raw.push_back(~pid[i]);
    r = 16'hFFFF;
    for (int k = 0; k < nbytes; k++) begin
      b = model_bytes[k];
      for (int i = 0; i < 8; i++) begin
        raw.push_back(b[i]);
        fb = b[i] ^ r[15];
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    if (with_crc) for (int i = 0; i < 16; i++) raw.push_back(~r[15-i]);
    ones = 0;
    foreach (raw[i]) begin
      st.push_back(raw[i]);
      if (raw[i]) begin
        ones++;
        if (ones == 6) begin
          st.push_back(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    lvl = 1'b1;
    foreach (st[i]) begin
      if (!st[i]) lvl = ~lvl;
      repeat (BT) exp_q.push_back({lvl, ~lvl});
    end
    repeat (2*BT) exp_q.push_back(2'b00);
    repeat (BT) exp_q.push_back(2'b10);
  endtask

  task automatic run_packet(input string name, input logic [1:0] pkt, input int exp_gets,
                            input int exp_errs, input bit hold);
    int mism, first, nerr, inact;
    logic [1:0] got, first_got, first_exp;
    get_cnt = 0; mism = 0; first = -1; nerr = 0; inact = 0;
    first_got = 2'b00; first_exp = 2'b00;
    TX_Packet = pkt;
    TX_Start  = 1'b1;
    @(negedge clk);
    if (!hold) TX_Start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = {Dplus_Out, Dminus_Out};
      if (got !== exp_q[i]) begin
        if (first < 0) begin
          first = i; first_got = got; first_exp = exp_q[i];
        end
        mism++;
      end
      if (TX_Transfer_Active !== 1'b1) inact++;
      if (TX_Error === 1'b1) nerr++;
      @(negedge clk);
    end
    if (TX_Error === 1'b1) nerr++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL %s lines: %0d bad clocks, first at %0d got %b required %b", name, mism, first, first_got, first_exp);
    end
    checks++;
    if (inact != 0) begin
      errors++;
      $display("FAIL %s active_during: %0d low clocks, required 0 over %0d", name, inact, exp_q.size());
    end
    checks++;
    if (TX_Transfer_Active !== 1'b0) begin
      errors++;
      $display("FAIL %s active_after: got %b required 0", name, TX_Transfer_Active);
    end
    checks++;
    if ({Dplus_Out, Dminus_Out} !== 2'b10) begin
      errors++;
      $display("FAIL %s idle_j: got %b required 10", name, {Dplus_Out, Dminus_Out});
    end
    checks++;
    if (nerr != exp_errs) begin
      errors++;
      $display("FAIL %s tx_error: got %0d pulses required %0d", name, nerr, exp_errs);
    end
    checks++;
    if (get_cnt != exp_gets) begin
      errors++;
      $display("FAIL %s get_strobes: got %0d required %0d", name, get_cnt, exp_gets);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Dplus_Out, Dminus_Out, TX_Transfer_Active, TX_Error, Get_TX_Packet_Data} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 10000",
               {Dplus_Out, Dminus_Out, TX_Transfer_Active, TX_Error, Get_TX_Packet_Data});
    end
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({Dplus_Out, Dminus_Out, TX_Transfer_Active} !== 3'b100) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 100", {Dplus_Out, Dminus_Out, TX_Transfer_Active});
    end
  endtask

  task automatic test_handshake();
    string nm[3] = '{"ack", "nak", "stall"};
    for (int p = 1; p <= 3; p++) begin
      model_bytes.delete();
      build_exp(2'(p), 0, 1'b0);
      checks++;
      if (exp_q.size() != 19*BT) begin
        errors++;
        $display("FAIL %s length: got %0d required %0d", nm[p-1], exp_q.size(), 19*BT);
      end
      run_packet(nm[p-1], 2'(p), 0, 0, 1'b0);
    end
  endtask

  task automatic test_data_zero();
    bq.delete(); refresh_buf();
    model_bytes.delete();
    build_exp(2'd0, 0, 1'b1);
    run_packet("data_zero", 2'd0, 0, 0, 1'b0);
  endtask

  task automatic load_bytes(input int n, input bit ff_only);
    logic [7:0] b;
    bq.delete(); model_bytes.delete();
    for (int i = 0; i < n; i++) begin
      b = (ff_only || ($urandom_range(0, 3) == 0)) ? 8'hFF : 8'($urandom);
      bq.push_back(b);
      model_bytes.push_back(b);
    end
    refresh_buf();
  endtask

  task automatic test_data_ff();
    load_bytes(1, 1'b1);
    build_exp(2'd0, 1, 1'b1);
    run_packet("data_ff", 2'd0, 1, 0, 1'b0);
  endtask

  task automatic test_data_random();
    int n;
    for (int t = 0; t < 4; t++) begin
      n = (t == 0) ? 64 : $urandom_range(1, 63);
      load_bytes(n, 1'b0);
      build_exp(2'd0, n, 1'b1);
      run_packet($sformatf("data_rand%0d_n%0d", t, n), 2'd0, n, 0, 1'b0);
      checks++;
      if (bq.size() != 0) begin
        errors++;
        $display("FAIL data_rand%0d drained: got %0d left required 0", t, bq.size());
      end
    end
  endtask

  task automatic test_underflow();
    load_bytes(2, 1'b0);
    drain_after_one = 1'b1;
    build_exp(2'd0, 1, 1'b0);
    run_packet("underflow", 2'd0, 1, 1, 1'b0);
    drain_after_one = 1'b0;
    bq.delete(); refresh_buf();
  endtask

  task automatic test_overflow();
    int nerr, act, notj;
    nerr = 0; act = 0; notj = 0;
    force_occ  = 1'b1;
    forced_occ = 7'($urandom_range(65, 127));
    TX_Packet  = 2'd0;
    TX_Start   = 1'b1;
    @(negedge clk);
    TX_Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (TX_Error === 1'b1) nerr++;
      if (TX_Transfer_Active !== 1'b0) act++;
      if ({Dplus_Out, Dminus_Out} !== 2'b10) notj++;
      @(negedge clk);
    end
    force_occ = 1'b0;
    checks++;
    if (nerr != 1) begin
      errors++;
      $display("FAIL overflow_error: got %0d pulses required 1 (occ %0d)", nerr, forced_occ);
    end
    checks++;
    if (act != 0 || notj != 0) begin
      errors++;
      $display("FAIL overflow_idle: got %0d active and %0d non-J clocks required 0", act, notj);
    end
  endtask

  task automatic test_reset_mid();
    TX_Packet = 2'd1;
    TX_Start  = 1'b1;
    @(negedge clk);
    TX_Start = 1'b0;
    repeat (10*BT - 1) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({Dplus_Out, Dminus_Out, TX_Transfer_Active, TX_Error, Get_TX_Packet_Data} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid: got %b required 10000",
               {Dplus_Out, Dminus_Out, TX_Transfer_Active, TX_Error, Get_TX_Packet_Data});
    end
    n_rst = 1'b1;
    @(negedge clk);
    model_bytes.delete();
    build_exp(2'd2, 0, 1'b0);
    run_packet("after_reset_nak", 2'd2, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    model_bytes.delete();
    build_exp(2'd1, 0, 1'b0);
    run_packet("b2b_first", 2'd1, 0, 0, 1'b1);
    run_packet("b2b_second", 2'd1, 0, 0, 1'b0);
  endtask

  initial begin
    refresh_buf();
    test_reset();
    test_handshake();
    test_data_zero();
    test_data_ff();
    test_data_random();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_tx.md
USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have these ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: n_rst  in  1  reset, synchronous and active-low.
REQ-003 SHALL have: TX_Start  in  1  request to transmit a packet, sampled in IDLE only.
REQ-004 SHALL have: TX_Packet  in  2  packet type: 0=DATA0, 1=ACK, 2=NAK, 3=STALL.
REQ-005 SHALL have: Buffer_Occupancy  in  7  bytes currently in the TX buffer, 0..64.
REQ-006 SHALL have: TX_Packet_Data  in  8  head byte of a first-word-fall-through TX buffer.
REQ-007 SHALL have: Dplus_Out and Dminus_Out  out  1 each  USB line drive.
REQ-008 SHALL have: TX_Transfer_Active  out  1  high while a packet is on the lines.
REQ-009 SHALL have: TX_Error  out  1  one-clock error pulse.
REQ-010 SHALL have: Get_TX_Packet_Data  out  1  one-clock pop strobe to the buffer.

Function
REQ-011 SHALL use states IDLE, SYNC, PID, DATA, CRC, EOP.
REQ-012 SHALL send one bit per clock, LSB first, unless USB_TX_DIV4_EN is defined.
REQ-013 IDLE SHALL drive J: Dplus_Out=1, Dminus_Out=0.
REQ-014 SHALL NRZI-encode: bit 0 toggles both lines; bit 1 holds the previous line state.
REQ-015 When IDLE and TX_Start=1 at an edge, SHALL latch TX_Packet and Buffer_Occupancy, then drive the first SYNC bit and TX_Transfer_Active=1 starting the next clock.
REQ-016 SYNC SHALL send, in time order, 0,0,0,0,0,0,0,1.
REQ-017 PID SHALL send PID[3:0] then ~PID[3:0], LSB first.
REQ-018 PID codes SHALL be DATA0=0011, ACK=0010, NAK=1010, STALL=1110.
REQ-019 ACK, NAK and STALL SHALL go from PID directly to EOP.
REQ-020 DATA0 SHALL send N bytes, where N is the latched occupancy, then CRC, then EOP; N=0 skips DATA.
REQ-021 For each data byte, SHALL assert Get_TX_Packet_Data for exactly one clock and capture TX_Packet_Data on the edge ending that clock.
REQ-022 The capture in REQ-021 SHALL occur during the last bit time of the preceding field, so no gap occurs between bytes.
REQ-023 CRC SHALL be CRC-16, polynomial x^16+x^15+x^2+1, initialised to 0xFFFF, computed over data bytes only.
REQ-024 SHALL transmit the one's complement of the CRC remainder, 16 bits, LSB first.
REQ-025 SHALL apply bit stuffing after six consecutive 1 bits: insert a 0 from the last SYNC bit through the last CRC bit, including a stuff bit owed after the final CRC bit.
REQ-026 Stuffed bits SHALL NOT advance the field bit counters or the CRC.
REQ-027 EOP SHALL drive SE0 (both lines 0) for 2 bit times, then J for 1 bit time, then return to IDLE.
REQ-028 TX_Transfer_Active SHALL fall on the return to IDLE.
REQ-029 If latched N>64 at start, SHALL pulse TX_Error for one clock and stay IDLE with no line activity.
REQ-030 Underflow SHALL be detected when a data byte is needed and Buffer_Occupancy=0.
REQ-031 On underflow, SHALL pulse TX_Error, skip the remaining DATA and CRC, and go to EOP.
REQ-032 TX_Error SHALL remain 0 during a normal packet.
REQ-033 TX_Start held high SHALL start a new packet at the first IDLE edge after the previous packet completes.
REQ-034 TX_Start changes during a packet SHALL be ignored.

Reset
REQ-035 With n_rst=0 at a rising edge, SHALL enter IDLE.
REQ-036 Reset SHALL set Dplus_Out=1, Dminus_Out=0, TX_Transfer_Active=0, TX_Error=0, Get_TX_Packet_Data=0.
REQ-037 Reset SHALL clear all counters and the CRC to 0xFFFF.
REQ-038 Reset mid-packet SHALL abort immediately with no EOP.

Configuration
REQ-039 Macro USB_TX_DIV4_EN defined: each bit time SHALL be 4 clocks, for a 48 MHz clock.
REQ-040 With USB_TX_DIV4_EN defined, line changes SHALL occur on divider wrap, and Get_TX_Packet_Data SHALL still be one clock wide.
REQ-041 Macro USB_TX_DIV4_EN undefined: each bit time SHALL be 1 clock.

Verification
REQ-042 ACK: reset, TX_Start=1, TX_Packet=1 -> SYNC, then bits 0,1,0,0,1,0,1,1, then SE0 x2, then J; Active high for exactly 19 clocks.
REQ-043 NAK and STALL: same flow with PID 1010 and 1110; no Get_TX_Packet_Data, TX_Error stays 0.
REQ-044 DATA0, occupancy 0 -> SYNC, PID 0011, 16 CRC bits all 0 (16 toggles), then EOP; zero Get strobes.
REQ-045 DATA0, 1 byte 0xFF -> one Get strobe, stuffed 0 after the sixth 1, CRC matches the reference model, correct EOP.
REQ-046 DATA0, occupancy 2 with the buffer draining to 0 after one pop -> TX_Error pulse at the second byte fetch, then EOP; Active falls.
REQ-047 n_rst=0 mid-PID -> next clock lines at J and all outputs 0; a new TX_Start then transmits normally.
